gradient_scroll_fader: RTL
==========================

Name: gradient_scroll_fader

Overview:
- Parametrised successor to the fixed 40-LED fader top. Generates a scrolling, linearly interpolated colour gradient as a byte stream for a WS2812-style serialiser.
- Holds a shift store of milestone colours and interpolates between adjacent milestones per LED and per channel. The gradient advances one LED position each frame; when the phase wraps, a new milestone colour is pulled in from an upstream random source.
- Sits between randomized_lfsr (colour source) and ws2812_output (trigger/data_req consumer).

Parameters:
- LEDS, 40, LEDs per frame (≥1).
- INTERP, 8, interpolation steps between milestones; power of two, ≥2.
- CHANNELS, 3, bytes per LED (3 = RGB, 4 = RGBW).
- HOLDOFF, 1200000, idle cycles between frames (0 allowed).
- Derived, not overridable: MS = (LEDS+INTERP-2)/INTERP + 2 milestones; IW = log2(INTERP).

Ports:
- CLK  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- color_in  in  8*CHANNELS  next milestone colour; channel c is bits [8c+7:8c].
- color_take  out  1  one-cycle pulse on the cycle color_in is sampled.
- data_req  in  1  one-cycle pulse: consumer has taken out_data, advance to the next byte.
- frame_start  out  1  one-cycle pulse starting a frame; drives the serialiser trigger.
- out_data  out  8  current byte (registered).
- busy  out  1  high while in STREAM.
- phase  out  IW  current scroll phase.

Behaviour:
- Reset is synchronous and active-high, and applies equally mid-frame:
  - store ← 0, phase ← 0, led/chan counters ← 0, holdoff counter ← HOLDOFF, state ← HOLD.
  - frame_start, color_take, busy ← 0; out_data ← 0.
- State machine, HOLD → TRIGGER → STREAM → END → HOLD:
  - HOLD: holdoff counter decrements each cycle; leaves when the counter is 0, so HOLD lasts HOLDOFF+1 cycles. data_req is ignored.
  - TRIGGER: one cycle, frame_start=1. data_req is ignored.
  - STREAM: busy=1. On each data_req, chan increments. When chan=CHANNELS-1, chan ← 0 and led increments. A data_req on the final byte (led=LEDS-1, chan=CHANNELS-1) moves to END.
  - END: one cycle. led, chan ← 0; holdoff counter ← HOLDOFF.
    - If phase < INTERP-1: phase ← phase+1.
    - Else: phase ← 0; store shifts down (m[j] ← m[j+1]); m[MS-1] ← color_in; color_take=1.
- Byte computation:
  - pos = led + phase; m = pos >> IW; i = pos mod INTERP.
  - lin = (m[m].c*(INTERP-i) + m[m+1].c*i) >> IW, computed at full 8+IW+1 width and truncated to 8 bits. Endpoints are exact: equal milestones give the same value.
  - m+1 ≤ MS-1 always holds; there is no out-of-range index.
- out_data is registered from the current counters every cycle.
  - It is updated two cycles after an advancing data_req. The consumer guarantees data_req pulses are ≥3 cycles apart.
  - Counters are at byte 0 throughout HOLD, so out_data is valid for byte 0 by TRIGGER.
- Byte order: LED 0 first; within an LED, channel 0 first.
- Successive frames scroll the pattern toward LED 0 by one position. The wrap-and-shift is seamless: no visual discontinuity.
- Zero-LED frames are not supported (LEDS ≥ 1).

Optional Feature:
- Macro: GRADIENT_GAMMA_EN.
- Defined: out_data = (lin*lin) >> 8 (square-law gamma), adding one register stage. out_data latency becomes 3 cycles after data_req; pulse spacing requirement becomes ≥4.
- Undefined: out_data = lin, latency 2.

Test Plan:
All scenarios use LEDS=4, INTERP=4, CHANNELS=3, HOLDOFF=3, so MS=3. color_in held at 0xFFFFFF. The bench pulses data_req every 4 cycles in STREAM.
- Reset → frame_start first pulses 4 cycles after reset deassert. Frame 0 outputs 12 bytes of 0x00, busy high for 12 data_req, phase goes 0→1.
- Frames 0–3 → a single color_take pulse in the END of frame 3; phase reads 0 at frame 4; no color_take in END of frames 0–2.
- Frame 6 (phase 2) → LED3 bytes all 0x3F, LEDs 0–2 0x00. Frame 7 → LED2 0x3F, LED3 0x7F.
- After frame 11 (store all 0xFFFFFF) → every byte in frame 12 is 0xFF. With GRADIENT_GAMMA_EN: 0xFE, and frame 6 LED3 is 0x0F.
- Assert rst mid-STREAM (LED 2) → next cycle busy=0, out_data=0x00, phase=0; the next frame replays the frame 0 sequence exactly.
- data_req pulses during HOLD/TRIGGER → no counter change; the frame still yields exactly 12 bytes.

Source files
------------

// File: rtl/gradient_scroll_fader.sv
// Scrolling milestone-interpolated colour gradient, streamed byte-by-byte to a WS2812 serialiser.
// Optional square-law gamma stage enabled by defining GRADIENT_GAMMA_EN.
module gradient_scroll_fader #(
   parameter int LEDS     = 40,
   parameter int INTERP   = 8,
   parameter int CHANNELS = 3,
   parameter int HOLDOFF  = 1200000,
   localparam int IW      = $clog2(INTERP)
) (
   input  logic                  CLK,
   input  logic                  rst,
   input  logic [8*CHANNELS-1:0] color_in,
   output logic                  color_take,
   input  logic                  data_req,
   output logic                  frame_start,
   output logic [7:0]            out_data,
   output logic                  busy,
   output logic [IW-1:0]         phase
);

   localparam int MS = (LEDS + INTERP - 2) / INTERP + 2;
   localparam int MW = $clog2(MS);
   localparam int LW = (LEDS > 1) ? $clog2(LEDS) : 1;
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam int PW = $clog2(LEDS + INTERP);
   localparam int XW = 8 + IW + 1;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_TRIGGER = 2'd1,
      ST_STREAM  = 2'd2,
      ST_END     = 2'd3
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [LW-1:0]         led_r;
   logic [CW-1:0]         chan_r;
   logic [HW-1:0]         hold_r;
   logic [IW-1:0]         phase_r;
   logic [8*CHANNELS-1:0] ms_r [MS];
   logic                  last_s;
   logic                  wrap_s;
   logic                  frame_start_s;
   logic                  busy_s;
   logic                  take_s;
   logic [PW-1:0]         pos_s;
   logic [MW-1:0]         m_s;
   logic [MW-1:0]         mn_s;
   logic [IW-1:0]         w_s;
   logic [7:0]            a_r;
   logic [7:0]            b_r;
   logic [IW-1:0]         w_r;
   logic [XW-1:0]         acc_s;
   logic [7:0]            lin_s;

   assign last_s = (led_r == LW'(LEDS - 1)) && (chan_r == CW'(CHANNELS - 1));
   assign wrap_s = (phase_r == IW'(INTERP - 1));
   assign phase  = phase_r;

   // State register and registered control outputs
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_r     <= ST_HOLD;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         color_take  <= 1'b0;
      end else begin
         state_r     <= state_s;
         frame_start <= frame_start_s;
         busy        <= busy_s;
         color_take  <= take_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_HOLD: begin
            if (hold_r == HW'(0)) state_s = ST_TRIGGER;
            else                  state_s = ST_HOLD;
         end
         ST_TRIGGER: state_s = ST_STREAM;
         ST_STREAM: begin
            if (data_req && last_s) state_s = ST_END;
            else                    state_s = ST_STREAM;
         end
         ST_END:  state_s = ST_HOLD;
         default: state_s = ST_HOLD;
      endcase
   end

   // Output decode from the upcoming state so the ports stay registered
   always_comb begin
      frame_start_s = (state_s == ST_TRIGGER);
      busy_s        = (state_s == ST_STREAM);
      take_s        = (state_s == ST_END) && wrap_s;
   end

   // Frame counters, scroll phase and milestone store
   always_ff @(posedge CLK) begin
      if (rst) begin
         led_r   <= LW'(0);
         chan_r  <= CW'(0);
         hold_r  <= HW'(HOLDOFF);
         phase_r <= IW'(0);
         for (int j = 0; j < MS; j++) ms_r[j] <= (8*CHANNELS)'(0);
      end else begin
         case (state_r)
            ST_HOLD: begin
               if (hold_r != HW'(0)) hold_r <= hold_r - HW'(1);
            end
            ST_STREAM: begin
               // The final byte parks the counters at byte 0 so the index never overruns
               if (data_req) begin
                  if (last_s) begin
                     led_r  <= LW'(0);
                     chan_r <= CW'(0);
                  end else if (chan_r == CW'(CHANNELS - 1)) begin
                     chan_r <= CW'(0);
                     led_r  <= led_r + LW'(1);
                  end else begin
                     chan_r <= chan_r + CW'(1);
                  end
               end
            end
            ST_END: begin
               led_r  <= LW'(0);
               chan_r <= CW'(0);
               hold_r <= HW'(HOLDOFF);
               if (wrap_s) begin
                  phase_r <= IW'(0);
                  for (int j = 0; j < MS - 1; j++) ms_r[j] <= ms_r[j+1];
                  ms_r[MS-1] <= color_in;
               end else begin
                  phase_r <= phase_r + IW'(1);
               end
            end
            default: begin
               hold_r <= hold_r;
            end
         endcase
      end
   end

   assign pos_s = PW'(led_r) + PW'(phase_r);
   assign m_s   = MW'(pos_s >> IW);
   assign mn_s  = m_s + MW'(1);
   assign w_s   = pos_s[IW-1:0];

   // Stage 1: pick the two bracketing milestone bytes and the weight
   always_ff @(posedge CLK) begin
      if (rst) begin
         a_r <= 8'd0;
         b_r <= 8'd0;
         w_r <= IW'(0);
      end else begin
         a_r <= ms_r[m_s][{chan_r, 3'b000} +: 8];
         b_r <= ms_r[mn_s][{chan_r, 3'b000} +: 8];
         w_r <= w_s;
      end
   end

   assign acc_s = XW'(a_r) * (XW'(INTERP) - XW'(w_r)) + XW'(b_r) * XW'(w_r);
   assign lin_s = 8'(acc_s >> IW);

`ifdef GRADIENT_GAMMA_EN
   logic [7:0]  lin_r;
   logic [15:0] sq_s;

   assign sq_s = 16'(lin_r) * 16'(lin_r);

   // Stage 2/3: interpolated byte, then square-law gamma
   always_ff @(posedge CLK) begin
      if (rst) begin
         lin_r    <= 8'd0;
         out_data <= 8'd0;
      end else begin
         lin_r    <= lin_s;
         out_data <= 8'(sq_s >> 8);
      end
   end
`else
   // Stage 2: interpolated byte
   always_ff @(posedge CLK) begin
      if (rst) out_data <= 8'd0;
      else     out_data <= lin_s;
   end
`endif

endmodule
